// File: rtl/univ_shift_reg.sv
// univ_shift_reg: DEPTH x WIDTH universal shift register
// with fill tracking and a per-frame completion pulse.
module univ_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       sin_up,
  input  logic [WIDTH-1:0]       sin_dn,
  input  logic [WIDTH*DEPTH-1:0] pin,
  output logic [WIDTH-1:0]       sout_up,
  output logic [WIDTH-1:0]       sout_dn,
  output logic [WIDTH*DEPTH-1:0] pout,
  output logic [WIDTH*DEPTH-1:0] pout_n,
  output logic [CW-1:0]          fill_cnt,
  output logic                   full,
  output logic                   frame_done
);

  localparam int N = WIDTH*DEPTH;
  localparam logic [CW-1:0] FMAX = CW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH-1);

  logic [N-1:0]  q, q_nx;
  logic [CW-1:0] fill_q, fill_nx;
  logic [CW-1:0] scnt_q, scnt_nx;
  logic          fd_q, fd_nx;
  logic          shu, shd, ld, sh;

  assign shu = en & (mode == 2'b01);
  assign shd = en & (mode == 2'b10);
  assign ld  = en & (mode == 2'b11);
  assign sh  = shu | shd;

  always_comb begin
    q_nx    = q;
    fill_nx = fill_q;
    scnt_nx = scnt_q;
    fd_nx   = 1'b0;
    unique case (1'b1)
      shu: q_nx = {q[N-WIDTH-1:0], sin_up};
      shd: q_nx = {sin_dn, q[N-1:WIDTH]};
      ld: begin
        q_nx    = pin;
        fill_nx = FMAX;
        scnt_nx = '0;
      end
      default: ;
    endcase
    // Frame counter ignores direction; it only counts shifts.
    if (sh) begin
      if (fill_q != FMAX)
        fill_nx = fill_q + 1'b1;
      fd_nx   = (scnt_q == LAST);
      scnt_nx = fd_nx ? '0 : scnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= '0;
      fill_q <= '0;
      scnt_q <= '0;
      fd_q   <= 1'b0;
    end else begin
      q      <= q_nx;
      fill_q <= fill_nx;
      scnt_q <= scnt_nx;
      fd_q   <= fd_nx;
    end
  end

  assign sout_up    = q[N-1 -: WIDTH];
  assign sout_dn    = q[WIDTH-1:0];
  assign pout       = q;
  assign pout_n     = ~q;
  assign fill_cnt   = fill_q;
  assign full       = (fill_q == FMAX);
  assign frame_done = fd_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: randomized + directed bench for
// univ_shift_reg at WIDTH=1 and WIDTH=8, DEPTH=4.
module tb_univ_shift_reg;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst, en;
  logic [1:0] mode;

  logic su1, sd1, sou1, sod1, full1, fd1;
  logic [D-1:0] pin1, po1, pn1;
  logic [2:0] fc1;

  logic [7:0] su8, sd8, sou8, sod8;
  logic [8*D-1:0] pin8, po8, pn8;
  logic [2:0] fc8;
  logic full8, fd8;

  int tests = 0;
  int fails = 0;

  logic       m1 [D];
  logic [7:0] m8 [D];
  int mfill, mshift;
  bit mfd;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(1), .DEPTH(D)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .sin_up(su1), .sin_dn(sd1), .pin(pin1),
    .sout_up(sou1), .sout_dn(sod1),
    .pout(po1), .pout_n(pn1),
    .fill_cnt(fc1), .full(full1),
    .frame_done(fd1)
  );

  univ_shift_reg #(.WIDTH(8), .DEPTH(D)) u8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .sin_up(su8), .sin_dn(sd8), .pin(pin8),
    .sout_up(sou8), .sout_dn(sod8),
    .pout(po8), .pout_n(pn8),
    .fill_cnt(fc8), .full(full8),
    .frame_done(fd8)
  );

  function automatic logic [D-1:0] e_po1();
    logic [D-1:0] r;
    for (int i = 0; i < D; i++) r[i] = m1[i];
    return r;
  endfunction

  function automatic logic [8*D-1:0] e_po8();
    logic [8*D-1:0] r;
    for (int i = 0; i < D; i++) r[i*8 +: 8] = m8[i];
    return r;
  endfunction

  function automatic void bump();
    mfill  = (mfill < D) ? mfill + 1 : D;
    mshift = mshift + 1;
    mfd    = (mshift % D) == 0;
  endfunction

  // Drive control, take one edge, advance the model.
  task automatic step(input bit r, input bit e,
                      input logic [1:0] md);
    @(negedge clk);
    rst = r; en = e; mode = md;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < D; i++) begin
        m1[i] = 1'b0; m8[i] = 8'h00;
      end
      mfill = 0; mshift = 0; mfd = 0;
    end else if (e && md == 2'b01) begin
      for (int i = D-1; i > 0; i--) begin
        m1[i] = m1[i-1]; m8[i] = m8[i-1];
      end
      m1[0] = su1; m8[0] = su8;
      bump();
    end else if (e && md == 2'b10) begin
      for (int i = 0; i < D-1; i++) begin
        m1[i] = m1[i+1]; m8[i] = m8[i+1];
      end
      m1[D-1] = sd1; m8[D-1] = sd8;
      bump();
    end else if (e && md == 2'b11) begin
      for (int i = 0; i < D; i++) begin
        m1[i] = pin1[i]; m8[i] = pin8[i*8 +: 8];
      end
      mfill = D; mshift = 0; mfd = 0;
    end else begin
      mfd = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    pin1 = '1; pin8 = '1;
    step(1, 1, 2'b11);
    step(1, 1, 2'b11);
    tests++;
    if (po8 !== '0 || po1 !== '0) begin
      fails++;
      $display("FAIL reset_pout got %h/%h want 0",
               po8, po1);
    end
    tests++;
    if (pn8 !== '1 || pn1 !== '1) begin
      fails++;
      $display("FAIL reset_pout_n got %h/%h want ones",
               pn8, pn1);
    end
    tests++;
    if ({fc8, full8, fd8, sou8, sod8} !== '0) begin
      fails++;
      $display("FAIL reset_misc fc=%0d full=%b fd=%b",
               fc8, full8, fd8);
    end
  endtask

  task automatic test_siso();
    logic [7:0] sin_seq, sou_exp, fd_exp;
    int fe [8];
    sin_seq = 8'b0000_1101;
    sou_exp = 8'b0110_1000;
    fd_exp  = 8'b1000_1000;
    fe = '{1, 2, 3, 4, 4, 4, 4, 4};
    step(1, 0, 2'b00);
    for (int k = 0; k < 8; k++) begin
      su1 = sin_seq[k];
      su8 = 8'($urandom);
      step(0, 1, 2'b01);
      tests++;
      if (sou1 !== sou_exp[k]) begin
        fails++;
        $display("FAIL siso_sout edge%0d got %b want %b",
                 k+1, sou1, sou_exp[k]);
      end
      tests++;
      if (fc1 !== 3'(fe[k]) || full1 !== (fe[k] == D)) begin
        fails++;
        $display("FAIL siso_fill edge%0d got %0d/%b want %0d",
                 k+1, fc1, full1, fe[k]);
      end
      tests++;
      if (fd1 !== fd_exp[k]) begin
        fails++;
        $display("FAIL siso_fd edge%0d got %b want %b",
                 k+1, fd1, fd_exp[k]);
      end
      tests++;
      if (po8 !== e_po8()) begin
        fails++;
        $display("FAIL siso_w8 edge%0d got %h want %h",
                 k+1, po8, e_po8());
      end
    end
  endtask

  task automatic test_pipo();
    logic [31:0] w;
    int pulses;
    w = 32'hDDCCBBAA;
    pin8 = w;
    pin1 = 4'($urandom);
    step(0, 1, 2'b11);
    tests++;
    if (po8 !== w || sod8 !== 8'hAA || fc8 !== 3'd4) begin
      fails++;
      $display("FAIL pipo_load got %h sod=%h fc=%0d want %h",
               po8, sod8, fc8, w);
    end
    pulses = 0;
    sd8 = 8'h00;
    for (int k = 1; k <= 4; k++) begin
      pin8 = 32'($urandom);
      step(0, 1, 2'b10);
      w = w >> 8;
      pulses += int'(fd8);
      tests++;
      if (po8 !== w || sod8 !== w[7:0]) begin
        fails++;
        $display("FAIL pipo_shift%0d got %h/%h want %h",
                 k, po8, sod8, w);
      end
    end
    tests++;
    if (pulses != 1 || fd8 !== 1'b1) begin
      fails++;
      $display("FAIL pipo_fd got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_enable();
    logic [8*D-1:0] sp;
    logic [2:0] sf;
    step(1, 0, 2'b00);
    for (int k = 0; k < 2; k++) begin
      su8 = 8'($urandom);
      step(0, 1, 2'b01);
    end
    sp = po8; sf = fc8;
    for (int k = 0; k < 3; k++) begin
      su8 = ~su8; su1 = ~su1;
      step(0, 0, 2'($urandom));
      tests++;
      if (po8 !== sp || fc8 !== sf || fd8 !== 1'b0) begin
        fails++;
        $display("FAIL en_hold got %h/%0d/%b want %h/%0d/0",
                 po8, fc8, fd8, sp, sf);
      end
    end
    for (int k = 3; k <= 4; k++) begin
      su8 = 8'($urandom);
      step(0, 1, 2'b01);
      tests++;
      if (fd8 !== (k == 4) || po8 !== e_po8()) begin
        fails++;
        $display("FAIL en_shift%0d fd=%b po=%h want %h",
                 k, fd8, po8, e_po8());
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 2'b00);
    for (int k = 0; k < 3; k++) begin
      su8 = 8'($urandom);
      step(0, 1, 2'b01);
    end
    step(1, 1, 2'b01);
    tests++;
    if (fd8 !== 1'b0 || fc8 !== 3'd0 || po8 !== '0) begin
      fails++;
      $display("FAIL rstmid got fd=%b fc=%0d po=%h",
               fd8, fc8, po8);
    end
    for (int k = 1; k <= 4; k++) begin
      su8 = 8'($urandom);
      step(0, 1, 2'($urandom_range(1, 2)));
      tests++;
      if (fd8 !== (k == 4)) begin
        fails++;
        $display("FAIL rstmid_fd shift%0d got %b want %b",
                 k, fd8, k == 4);
      end
    end
  endtask

  task automatic test_load_mid();
    step(1, 0, 2'b00);
    for (int k = 0; k < 2; k++) begin
      su1 = 1'($urandom);
      step(0, 1, 2'b01);
    end
    pin1 = 4'h5;
    step(0, 1, 2'b11);
    tests++;
    if (po1 !== 4'h5 || fc1 !== 3'd4 || !full1) begin
      fails++;
      $display("FAIL ldmid got po=%h fc=%0d want 5/4",
               po1, fc1);
    end
    for (int k = 1; k <= 4; k++) begin
      su1 = 1'($urandom);
      step(0, 1, 2'b01);
      tests++;
      if (fd1 !== (k == 4) || sou1 !== m1[D-1]) begin
        fails++;
        $display("FAIL ldmid_shift%0d fd=%b sou=%b want %b/%b",
                 k, fd1, sou1, k == 4, m1[D-1]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      su1 = 1'($urandom); sd1 = 1'($urandom);
      su8 = 8'($urandom); sd8 = 8'($urandom);
      pin1 = 4'($urandom); pin8 = 32'($urandom);
      step($urandom_range(0, 40) == 0,
           $urandom_range(0, 4) != 0,
           2'($urandom));
      tests++;
      if (po8 !== e_po8() || pn8 !== ~e_po8() ||
          po1 !== e_po1() || pn1 !== ~e_po1()) begin
        fails++;
        $display("FAIL rnd_pout cyc%0d got %h/%h want %h/%h",
                 k, po8, po1, e_po8(), e_po1());
      end
      tests++;
      if (sou8 !== m8[D-1] || sod8 !== m8[0] ||
          sou1 !== m1[D-1] || sod1 !== m1[0]) begin
        fails++;
        $display("FAIL rnd_sout cyc%0d got %h/%h want %h/%h",
                 k, sou8, sod8, m8[D-1], m8[0]);
      end
      tests++;
      if (fc8 !== 3'(mfill) || full8 !== (mfill == D) ||
          fd8 !== mfd || fd1 !== mfd) begin
        fails++;
        $display("FAIL rnd_ctl cyc%0d got %0d/%b/%b want %0d/%b",
                 k, fc8, full8, fd8, mfill, mfd);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00;
    su1 = 1'b0; sd1 = 1'b0; pin1 = '0;
    su8 = '0; sd8 = '0; pin8 = '0;
    test_reset();
    test_siso();
    test_pipo();
    test_enable();
    test_reset_mid();
    test_load_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
